// File: rtl/rgb_mem_arbiter.sv
// Two-master arbiter for three 8-bit RGB plane memories.
// Arbitration alternates when both masters request, caps unlocked bursts and honours lock.
module rgb_mem_arbiter #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [2:0]  m0_wr,
  input  logic [13:0] m0_addr,
  input  logic [23:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [2:0]  m1_wr,
  input  logic [13:0] m1_addr,
  input  logic [23:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [23:0] rdata,
  output logic        wr_r,
  output logic        wr_g,
  output logic        wr_b,
  output logic [13:0] addr_r,
  output logic [13:0] addr_g,
  output logic [13:0] addr_b,
  output logic [7:0]  wdata_r,
  output logic [7:0]  wdata_g,
  output logic [7:0]  wdata_b,
  input  logic [7:0]  rdata_r,
  input  logic [7:0]  rdata_g,
  input  logic [7:0]  rdata_b
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e        state_q, state_d;
  logic          last_owner_q;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          m0_gnt_q, m1_gnt_q;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic          own_req;

  logic [2:0]    mux_wr;
  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_wdata;

  // Next-state arbitration
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = last_owner_q ? OWN0 : OWN1;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req)
          state_d = m1_req ? OWN1 : IDLE;
        else if (m1_req && !m0_lock && (burst_cnt_q == BURST_LAST))
          state_d = OWN1;
      end
      OWN1: begin
        if (!m1_req)
          state_d = m0_req ? OWN0 : IDLE;
        else if (m0_req && !m1_lock && (burst_cnt_q == BURST_LAST))
          state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst counter clears on any state change and saturates while the owner keeps requesting
  always_comb begin
    own_req     = ((state_q == OWN0) && m0_req) || ((state_q == OWN1) && m1_req);
    burst_cnt_d = burst_cnt_q;
    if (state_d != state_q)
      burst_cnt_d = '0;
    else if (own_req && (burst_cnt_q != BURST_LAST))
      burst_cnt_d = burst_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      m0_gnt_q    <= (state_d == OWN0);
      m1_gnt_q    <= (state_d == OWN1);
      if ((state_d == OWN0) && (state_q != OWN0)) last_owner_q <= 1'b0;
      if ((state_d == OWN1) && (state_q != OWN1)) last_owner_q <= 1'b1;
      // Read completes one cycle after a granted, write-free address
      m0_rvalid_q <= m0_gnt_q && m0_req && (m0_wr == 3'b000);
      m1_rvalid_q <= m1_gnt_q && m1_req && (m1_wr == 3'b000);
    end
  end

  // Owner's bus onto the memories; zero when nobody owns them
  always_comb begin
    mux_wr    = '0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (m0_gnt_q) begin
      mux_wr    = m0_req ? m0_wr : 3'b000;
      mux_addr  = m0_addr;
      mux_wdata = m0_wdata;
    end else if (m1_gnt_q) begin
      mux_wr    = m1_req ? m1_wr : 3'b000;
      mux_addr  = m1_addr;
      mux_wdata = m1_wdata;
    end
  end

  assign wr_r    = mux_wr[2];
  assign wr_g    = mux_wr[1];
  assign wr_b    = mux_wr[0];
  assign addr_r  = mux_addr;
  assign addr_g  = mux_addr;
  assign addr_b  = mux_addr;
  assign wdata_r = mux_wdata[23:16];
  assign wdata_g = mux_wdata[15:8];
  assign wdata_b = mux_wdata[7:0];
  assign rdata   = {rdata_r, rdata_g, rdata_b};

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;

endmodule

// File: tb/tb_rgb_mem_arbiter.sv
// Directed bench for rgb_mem_arbiter: arbitration, burst limit, lock, mux and read timing.
module tb_rgb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [2:0]  m0_wr, m1_wr;
  logic [13:0] m0_addr, m1_addr;
  logic [23:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [23:0] rdata;
  logic        wr_r, wr_g, wr_b;
  logic [13:0] addr_r, addr_g, addr_b;
  logic [7:0]  wdata_r, wdata_g, wdata_b;
  logic [7:0]  rdata_r, rdata_g, rdata_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rgb_mem_arbiter #(.MAX_BURST(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
    .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
    .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
    .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    m0_req = 0; m0_lock = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    rdata_r = 0; rdata_g = 0; rdata_b = 0;
    tick(); tick();
    chk("rst_m0_gnt", 32'(m0_gnt), 0);
    chk("rst_m1_gnt", 32'(m1_gnt), 0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
    chk("rst_addr", 32'(addr_r), 0);
    reset = 1'b0;

    // Simultaneous request out of reset: m0 first, m1 after m0 drops
    m0_req = 1; m1_req = 1;
    tick();
    chk("first_m0_gnt", 32'(m0_gnt), 1);
    chk("first_m1_gnt", 32'(m1_gnt), 0);
    tick(); tick();
    chk("hold_m0_gnt", 32'(m0_gnt), 1);
    m0_req = 0;
    tick();
    chk("handoff_m1_gnt", 32'({m0_gnt, m1_gnt}), 32'b01);
    m1_req = 0;
    tick();
    chk("idle_gnts", 32'({m0_gnt, m1_gnt}), 0);

    // Unlocked contention: grant alternates every 16 cycles, m0 first (last owner was m1)
    m0_req = 1; m1_req = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk($sformatf("burst_m0_c%0d", i), 32'(m0_gnt), 32'(((i - 1) / 16) % 2 == 0));
      chk($sformatf("burst_excl_c%0d", i), 32'(m0_gnt & m1_gnt), 0);
    end
    m0_req = 0; m1_req = 0;
    tick();

    // Locked owner keeps grant past the burst limit
    m0_req = 1; m0_lock = 1;
    tick();
    chk("lock_entry", 32'(m0_gnt), 1);
    m1_req = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk($sformatf("lock_c%0d", i), 32'({m0_gnt, m1_gnt}), 32'b10);
    end
    m0_req = 0; m0_lock = 0;
    tick();
    chk("lock_release", 32'({m0_gnt, m1_gnt}), 32'b01);
    m1_req = 0;
    tick();

    // m1 write muxing; m0 idle bus must not leak through
    m1_req = 1;
    m0_addr = 14'h1234; m0_wdata = 24'hFFFFFF; m0_wr = 3'b111;
    tick();
    chk("wr_own_m1", 32'(m1_gnt), 1);
    m1_wr = 3'b101; m1_addr = 14'h0081; m1_wdata = 24'hA0335C;
    #1;
    chk("wr_bits", 32'({wr_r, wr_g, wr_b}), 32'b101);
    chk("wr_addr_r", 32'(addr_r), 32'h0081);
    chk("wr_addr_g", 32'(addr_g), 32'h0081);
    chk("wr_addr_b", 32'(addr_b), 32'h0081);
    chk("wr_wdata", 32'({wdata_r, wdata_g, wdata_b}), 32'hA0335C);
    m1_req = 0;
    #1;
    chk("wr_drop_req", 32'({wr_r, wr_g, wr_b}), 0);
    tick();
    chk("idle_addr_zero", 32'({addr_r, wdata_r}), 0);
    m0_wr = 0; m1_wr = 0;

    // m0 read at top address; then a read in the last owned cycle still completes
    m0_req = 1;
    tick();
    chk("rd_own_m0", 32'(m0_gnt), 1);
    m0_addr = 14'h3FFF;
    #1;
    chk("rd_addr", 32'(addr_b), 32'h3FFF);
    chk("rd_no_write", 32'({wr_r, wr_g, wr_b}), 0);
    tick();
    rdata_r = 8'h11; rdata_g = 8'h22; rdata_b = 8'h33;
    #1;
    chk("rd_m0_rvalid", 32'(m0_rvalid), 1);
    chk("rd_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rd_rdata", 32'(rdata), 32'h112233);
    m1_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (m1_gnt) seen = 1;
    end
    chk("rd_switch_seen", 32'(seen), 1);
    chk("rd_last_rvalid_m0", 32'(m0_rvalid), 1);
    m0_req = 0;
    tick();
    chk("rd_after_m0_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'b01);
    m1_req = 0;
    tick();

    // Reset during an m1 locked write burst
    m1_req = 1; m1_lock = 1; m1_wr = 3'b111; m1_addr = 14'h0555; m1_wdata = 24'h123456;
    tick(); tick(); tick();
    chk("pre_rst_gnt", 32'(m1_gnt), 1);
    chk("pre_rst_wr", 32'({wr_r, wr_g, wr_b}), 32'b111);
    reset = 1'b1;
    #1;
    chk("rst_async_gnt", 32'({m0_gnt, m1_gnt}), 0);
    chk("rst_async_wr", 32'({wr_r, wr_g, wr_b}), 0);
    chk("rst_async_addr", 32'(addr_g), 0);
    chk("rst_async_wdata", 32'({wdata_r, wdata_g, wdata_b}), 0);
    tick();
    chk("rst_rvalid_next", 32'({m0_rvalid, m1_rvalid}), 0);
    m0_req = 1; m1_lock = 0; m1_wr = 0;
    reset = 1'b0;
    tick();
    chk("post_rst_m0_first", 32'({m0_gnt, m1_gnt}), 32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
